// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS_DEF  = 4;
  localparam int unsigned SLOT_CYCLES_DEF = 50000;
  localparam int unsigned DEAD_CYCLES_DEF = 100;

  // Segments are active-low, ordered {g,f,e,d,c,b,a}
  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  localparam logic [0:0] S_DEAD  = 1'b0;
  localparam logic [0:0] S_DRIVE = 1'b1;

endpackage

// File: rtl/bin_to_7seg.sv
// Hex nibble to active-low 7-segment pattern, {g,f,e,d,c,b,a}.
module bin_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0]       bin,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    case (bin)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous
// display updates and optional leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = NUM_DIGITS_DEF,
  parameter int unsigned SLOT_CYCLES = SLOT_CYCLES_DEF,
  parameter int unsigned DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    upd_valid,
  input  logic [4*NUM_DIGITS-1:0] upd_value,
  output logic                    upd_ready,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SEG_W-1:0]        seg,
  output logic                    frame_tick
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned CW = $clog2(SLOT_CYCLES);
  localparam int unsigned GW = $clog2(NUM_DIGITS);

  logic [0:0]            state, state_nxt;
  logic [CW-1:0]         slot_cnt;
  logic [GW-1:0]         dig;
  logic [DW-1:0]         disp_reg, pend_reg;
  logic                  pending;
  logic                  supp;
  logic [NUM_DIGITS-1:0] zmask;
  logic                  slot_end, last_dig, frame_end, tick_pre, dead_end, xfer;
  logic [3:0]            nib;
  logic [SEG_W-1:0]      dec_seg;

  assign slot_end  = (slot_cnt == CW'(SLOT_CYCLES - 1));
  assign dead_end  = (slot_cnt == CW'(DEAD_CYCLES - 1));
  assign last_dig  = (dig == GW'(NUM_DIGITS - 1));
  assign frame_end = slot_end && last_dig;
  assign tick_pre  = last_dig && (slot_cnt == CW'(SLOT_CYCLES - 2));
  assign upd_ready = !pending && !rst;
  assign xfer      = upd_valid && upd_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_DEAD;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_DEAD:  if (dead_end) state_nxt = S_DRIVE;
      S_DRIVE: if (slot_end) state_nxt = S_DEAD;
      default: state_nxt = S_DEAD;
    endcase
  end

  // Slot timer and digit pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      dig      <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      dig      <= last_dig ? '0 : dig + GW'(1);
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  // zmask[i]: every nibble from i up to the top is zero
  always_comb begin
    zmask = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      zmask[i] = ((disp_reg >> (4 * i)) == '0);
  end

  // Suppression is decided once per slot so a digit never flickers mid-slot
  always_ff @(posedge clk) begin
    if (rst)
      supp <= 1'b0;
    else if (state == S_DEAD && dead_end)
      supp <= lz_en && (dig != '0) && zmask[dig];
  end

  // Update handshake; new data only lands on a frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg   <= '0;
      pend_reg   <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick_pre;
      if (frame_end && pending) begin
        disp_reg <= pend_reg;
        pending  <= 1'b0;
      end else if (xfer) begin
        pend_reg <= upd_value;
        pending  <= 1'b1;
      end
    end
  end

  assign nib = disp_reg[{dig, 2'b00} +: 4];

  bin_to_7seg u_dec (
    .bin   (nib),
    .seg_c (dec_seg)
  );

  // Digit drive decoded from registered state only
  always_comb begin
    an  = '1;
    seg = SEG_OFF;
    if (state == S_DRIVE && !supp) begin
      an[dig] = 1'b0;
      seg     = dec_seg;
    end
  end

endmodule
